// File: rtl/morra_cinese_param.sv
// Parametrised rock-paper-scissors match controller: per-cycle round arbitration,
// running score and a lead/minimum/maximum match-end rule.
module morra_cinese_param #(
    parameter int MIN_MANCHE  = 4,
    parameter int BASE_MANCHE = 4,
    parameter int LEAD        = 2,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             INIZIO,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic [CNT_W-1:0] PUNTI_1,
    output logic [CNT_W-1:0] PUNTI_2,
    output logic [CNT_W-1:0] NUM_MANCHE,
    output logic             ATTIVA
);

    typedef enum logic {ATTESA = 1'b0, GIOCO = 1'b1} state_t;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_MANCHE);
    localparam logic [CNT_W:0]   MIN_C  = (CNT_W+1)'(MIN_MANCHE);
    localparam logic [CNT_W:0]   LEAD_C = (CNT_W+1)'(LEAD);

    function automatic logic [1:0] round_result(input logic [1:0] a, input logic [1:0] b);
        if (a == b)
            return RES_DRAW;
        if ((a == 2'b10 && b == 2'b01) || (a == 2'b01 && b == 2'b11) ||
            (a == 2'b11 && b == 2'b10))
            return RES_P1;
        return RES_P2;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   max_q, num_q, num_d, p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         pw_q, pw_d, pm_q, pm_d;
    logic [1:0]         manche_q, manche_d, partita_q, partita_d;
    logic               attiva_q, attiva_d;

    logic [1:0]         res;
    logic               valid;
    logic [CNT_W-1:0]   n_nx, p1_nx, p2_nx;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]     absd;
    logic               lead_end, max_end;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        pw_d      = pw_q;
        pm_d      = pm_q;
        manche_d  = RES_NONE;
        partita_d = RES_NONE;
        attiva_d  = attiva_q;

        res   = round_result(PRIMO, SECONDO);
        // The previous winner may not reuse the move that just won; draws reset this.
        valid = (PRIMO != 2'b00) && (SECONDO != 2'b00) &&
                !(pw_q == RES_P1 && PRIMO == pm_q) &&
                !(pw_q == RES_P2 && SECONDO == pm_q);

        n_nx  = num_q + 1'b1;
        p1_nx = p1_q + {{(CNT_W-1){1'b0}}, (res == RES_P1)};
        p2_nx = p2_q + {{(CNT_W-1){1'b0}}, (res == RES_P2)};
        diff  = $signed({1'b0, p1_nx}) - $signed({1'b0, p2_nx});
        absd  = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
        lead_end = ({1'b0, n_nx} >= MIN_C) && (absd >= LEAD_C);
        max_end  = (n_nx == max_q);

        if (state_q == GIOCO) begin
            if (valid) begin
                num_d    = n_nx;
                p1_d     = p1_nx;
                p2_d     = p2_nx;
                manche_d = res;
                pw_d     = (res == RES_DRAW) ? RES_NONE : res;
                pm_d     = (res == RES_P2) ? SECONDO : PRIMO;
                if (lead_end)
                    partita_d = (diff > 0) ? RES_P1 : RES_P2;
                else if (max_end)
                    partita_d = (diff > 0) ? RES_P1 : ((diff < 0) ? RES_P2 : RES_DRAW);
                // ATTIVA stays high through the PARTITA cycle and drops afterwards.
                if (lead_end || max_end)
                    state_d = ATTESA;
            end
        end else begin
            attiva_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (INIZIO) begin
            state_q   <= GIOCO;
            max_q     <= BASE_C + CNT_W'({PRIMO, SECONDO});
            num_q     <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            pw_q      <= RES_NONE;
            pm_q      <= 2'b00;
            manche_q  <= RES_NONE;
            partita_q <= RES_NONE;
            attiva_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            pw_q      <= pw_d;
            pm_q      <= pm_d;
            manche_q  <= manche_d;
            partita_q <= partita_d;
            attiva_q  <= attiva_d;
        end
    end

    assign MANCHE     = manche_q;
    assign PARTITA    = partita_q;
    assign PUNTI_1    = p1_q;
    assign PUNTI_2    = p2_q;
    assign NUM_MANCHE = num_q;
    assign ATTIVA     = attiva_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Bench for morra_cinese_param: behavioural match model checked every cycle,
// plus directed rounds with hand-computed expectations.
module tb_morra_cinese_param;

    localparam int M_MIN = 4, M_BASE = 4, M_LEAD = 2, W = 5;

    logic clk = 1'b0;
    logic INIZIO = 1'b0;
    logic [1:0] PRIMO = 2'b00, SECONDO = 2'b00;
    logic [1:0] MANCHE, PARTITA, MANCHE2, PARTITA2;
    logic [W-1:0] PUNTI_1, PUNTI_2, NUM_MANCHE, PUNTI_1b, PUNTI_2b, NUM_MANCHEb;
    logic ATTIVA, ATTIVA2;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    morra_cinese_param #(.MIN_MANCHE(M_MIN), .BASE_MANCHE(M_BASE), .LEAD(M_LEAD), .CNT_W(W)) dut (
        .clk(clk), .INIZIO(INIZIO), .PRIMO(PRIMO), .SECONDO(SECONDO),
        .MANCHE(MANCHE), .PARTITA(PARTITA), .PUNTI_1(PUNTI_1), .PUNTI_2(PUNTI_2),
        .NUM_MANCHE(NUM_MANCHE), .ATTIVA(ATTIVA));

    morra_cinese_param #(.MIN_MANCHE(2), .BASE_MANCHE(4), .LEAD(3), .CNT_W(W)) dut2 (
        .clk(clk), .INIZIO(INIZIO), .PRIMO(PRIMO), .SECONDO(SECONDO),
        .MANCHE(MANCHE2), .PARTITA(PARTITA2), .PUNTI_1(PUNTI_1b), .PUNTI_2(PUNTI_2b),
        .NUM_MANCHE(NUM_MANCHEb), .ATTIVA(ATTIVA2));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: beats[m] is the move that m defeats.
    int beats [4] = '{0, 3, 1, 2};
    bit m_def = 0, m_active = 0;
    int m_max, m_n, m_s1, m_s2, m_lw, m_lm;
    int e_manche = 0, e_partita = 0, e_attiva = 0;

    always @(posedge clk) begin
        int a, b, r, d;
        bit ok;
        a = int'(PRIMO);
        b = int'(SECONDO);
        if (INIZIO) begin
            m_def = 1; m_active = 1;
            m_max = M_BASE + a * 4 + b;
            m_n = 0; m_s1 = 0; m_s2 = 0; m_lw = 0; m_lm = 0;
            e_manche = 0; e_partita = 0; e_attiva = 1;
        end else if (m_def) begin
            e_manche = 0; e_partita = 0;
            if (m_active) begin
                ok = (a != 0) && (b != 0) && !(m_lw == 1 && a == m_lm) && !(m_lw == 2 && b == m_lm);
                if (ok) begin
                    if (a == b) r = 3;
                    else if (beats[a] == b) r = 1;
                    else r = 2;
                    m_n++;
                    if (r == 1) begin m_s1++; m_lw = 1; m_lm = a; end
                    else if (r == 2) begin m_s2++; m_lw = 2; m_lm = b; end
                    else m_lw = 0;
                    e_manche = r;
                    d = m_s1 - m_s2;
                    if (d < 0) d = -d;
                    if (m_n >= M_MIN && d >= M_LEAD) e_partita = (m_s1 > m_s2) ? 1 : 2;
                    else if (m_n == m_max) e_partita = (m_s1 > m_s2) ? 1 : ((m_s2 > m_s1) ? 2 : 3);
                    if (e_partita != 0) m_active = 0;
                end
            end else begin
                e_attiva = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_def) begin
            chk("model_manche", int'(MANCHE), e_manche);
            chk("model_partita", int'(PARTITA), e_partita);
            chk("model_punti1", int'(PUNTI_1), m_s1);
            chk("model_punti2", int'(PUNTI_2), m_s2);
            chk("model_num", int'(NUM_MANCHE), m_n);
            chk("model_attiva", int'(ATTIVA), e_attiva);
        end
    end

    task automatic cyc(input logic ini, input logic [1:0] a, input logic [1:0] b);
        INIZIO = ini; PRIMO = a; SECONDO = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int early;
        @(posedge clk); #1;

        // Lead win with a repeated winning move and a draw in between
        cyc(1, 2'b00, 2'b00);
        chk("rst_attiva", int'(ATTIVA), 1);
        chk("rst_num", int'(NUM_MANCHE), 0);
        chk("rst_partita", int'(PARTITA), 0);
        cyc(0, 2'b10, 2'b01); chk("t1_r1", int'(MANCHE), 1);
        cyc(0, 2'b01, 2'b11); chk("t1_r2", int'(MANCHE), 1);
        cyc(0, 2'b01, 2'b01); chk("t1_repeat", int'(MANCHE), 0);
        cyc(0, 2'b11, 2'b11); chk("t1_r3", int'(MANCHE), 3);
        chk("t1_r3_partita", int'(PARTITA), 0);
        cyc(0, 2'b01, 2'b01); chk("t1_r4", int'(MANCHE), 3);
        chk("t1_partita", int'(PARTITA), 1);
        chk("t1_p1", int'(PUNTI_1), 2);
        chk("t1_p2", int'(PUNTI_2), 0);
        chk("t1_num", int'(NUM_MANCHE), 4);
        chk("t1_attiva_hold", int'(ATTIVA), 1);
        cyc(0, 2'b00, 2'b00);
        chk("t1_attiva_fall", int'(ATTIVA), 0);
        chk("t1_partita_clear", int'(PARTITA), 0);

        // Repeat rule and invalid moves
        cyc(1, 2'b00, 2'b00);
        cyc(0, 2'b10, 2'b01); chk("t2_r1", int'(MANCHE), 1);
        cyc(0, 2'b10, 2'b11); chk("t2_repeat", int'(MANCHE), 0);
        chk("t2_num_hold", int'(NUM_MANCHE), 1);
        cyc(0, 2'b00, 2'b10); chk("t2_none", int'(MANCHE), 0);
        cyc(0, 2'b11, 2'b10); chk("t2_r2", int'(MANCHE), 1);
        chk("t2_num", int'(NUM_MANCHE), 2);

        // INIZIO held: last config (MAX=4) wins; tie at MAX
        cyc(1, 2'b11, 2'b11);
        cyc(1, 2'b00, 2'b00);
        cyc(0, 2'b10, 2'b01); chk("t3_r1", int'(MANCHE), 1);
        cyc(0, 2'b01, 2'b10); chk("t3_r2", int'(MANCHE), 2);
        cyc(0, 2'b10, 2'b01); chk("t3_r3", int'(MANCHE), 1);
        cyc(0, 2'b11, 2'b01); chk("t3_r4", int'(MANCHE), 2);
        chk("t3_partita", int'(PARTITA), 3);
        chk("t3_p1", int'(PUNTI_1), 2);
        chk("t3_p2", int'(PUNTI_2), 2);

        // Mid-match abort, then MAX=19 with alternating wins
        cyc(1, 2'b00, 2'b00);
        cyc(0, 2'b10, 2'b01);
        cyc(0, 2'b01, 2'b10);
        cyc(1, 2'b11, 2'b11);
        chk("t4_num0", int'(NUM_MANCHE), 0);
        chk("t4_p1_0", int'(PUNTI_1), 0);
        chk("t4_attiva", int'(ATTIVA), 1);
        early = 0;
        for (int k = 1; k <= 19; k++) begin
            if (k % 2 == 1) cyc(0, 2'b10, 2'b01);
            else            cyc(0, 2'b01, 2'b10);
            if (k < 19 && PARTITA != 2'b00) early++;
        end
        chk("t4_early_end", early, 0);
        chk("t4_partita", int'(PARTITA), 1);
        chk("t4_num", int'(NUM_MANCHE), 19);
        chk("t4_p1", int'(PUNTI_1), 10);
        chk("t4_p2", int'(PUNTI_2), 9);

        // ATTESA ignores moves and freezes scores
        for (int k = 0; k < 5; k++) begin
            cyc(0, 2'b10, 2'b01);
            chk("t5_manche", int'(MANCHE), 0);
            chk("t5_partita", int'(PARTITA), 0);
        end
        chk("t5_num", int'(NUM_MANCHE), 19);
        chk("t5_p1", int'(PUNTI_1), 10);
        chk("t5_attiva", int'(ATTIVA), 0);
        cyc(1, 2'b00, 2'b00);
        chk("t5_restart_attiva", int'(ATTIVA), 1);
        chk("t5_restart_num", int'(NUM_MANCHE), 0);

        // LEAD=3, MIN_MANCHE=2 instance: three straight P1 wins
        cyc(0, 2'b10, 2'b01);
        cyc(0, 2'b01, 2'b11);
        chk("t6_r2_partita", int'(PARTITA2), 0);
        cyc(0, 2'b11, 2'b10);
        chk("t6_r3_partita", int'(PARTITA2), 1);
        chk("t6_p1", int'(PUNTI_1b), 3);
        cyc(0, 2'b00, 2'b00);
        cyc(0, 2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
